npu_mem_loader: RTL and testbench
=================================

// Module: npu_mem_loader
// PURPOSE
//  Command-driven byte mover that sits directly upstream of the 512x8 NPU memories (ram512x8 instances).
//  Write command: streams bytes from a valid/ready source into one selected memory.
//  Read command: reads bytes back out of the memory onto a valid/ready sink.
//  It drives the memory's mem_adr/reg_adr/din/we and consumes its dout. The upstream side is the AHB/DMA glue.
// PARAMETERS
//  WIDTH     8   data width; must match the memory
//  MEMSEL_W  6   memory-select address width
//  REGSEL_W  9   in-memory address width (512 locations)
//  LEN_W     10  transfer-length width; transfer count = cmd_len
//  RFIFO_D   4   read-return FIFO depth, power of 2, >=4
// PORTS
//  clk        in   1         clock, all state on rising edge
//  rst_n      in   1         asynchronous active-low reset
//  cmd_valid  in   1         command strobe
//  cmd_ready  out  1         high only in IDLE
//  cmd_write  in   1         1=write transfer, 0=read transfer
//  cmd_mem    in   MEMSEL_W  target memory select
//  cmd_base   in   REGSEL_W  first location
//  cmd_len    in   LEN_W     number of bytes
//  wr_valid   in   1         write-data valid
//  wr_data    in   WIDTH     write byte
//  wr_ready   out  1         write byte accepted
//  rd_valid   out  1         read byte available
//  rd_data    out  WIDTH     read byte
//  rd_ready   in   1         sink accepts read byte
//  mem_adr    out  MEMSEL_W  to memory
//  reg_adr    out  REGSEL_W  to memory
//  din        out  WIDTH     to memory
//  we         out  1         to memory, active-high write enable
//  ram_dout   in   WIDTH     from memory
//  busy       out  1         high whenever state != IDLE
//  done       out  1         one-cycle pulse at end of command
// BEHAVIOUR
//  Reset: state=IDLE, we=0, mem_adr=0, reg_adr=0, din=0, rd_valid=0, busy=0, done=0, FIFO empty.
//   cmd_ready=1 from the first cycle after rst_n deasserts.
//  Handshakes: transfer occurs when valid&&ready on the same rising edge. Payloads must hold while valid&&!ready.
//  FSM: IDLE -> WRITE | READ on cmd accept. Registers mem/base/len; cnt=0.
//   cmd_len==0: IDLE -> DONE directly; no memory access occurs.
//   WRITE: wr_ready=1 while cnt<len. Each accepted byte registers we=1, din=wr_data,
//    reg_adr=(base+cnt) mod 2^REGSEL_W, mem_adr=mem for exactly the next cycle; cnt++.
//    Otherwise we=0. Full throughput is 1 byte/cycle. After the last byte -> DONE.
//   READ: an issue occurs when cnt<len and (fifo_count+inflight)<RFIFO_D.
//    An issue drives reg_adr/mem_adr (we=0) for the next cycle; cnt++.
//    ram_dout is valid the cycle after the address cycle, and is pushed into the FIFO on that edge.
//    An inflight counter tracks issued-but-unpushed reads (0..2).
//    When cnt==len: -> DRAIN.
//   DRAIN: wait for inflight==0 and FIFO empty, then -> DONE.
//   DONE: done=1 for one cycle -> IDLE.
//  Read FIFO: rd_valid=!empty. rd_data=head (first-word-fall-through). Pop on rd_valid&&rd_ready.
//   Simultaneous push/pop keeps the count unchanged. The credit rule guarantees no overflow.
//  Address arithmetic: REGSEL_W-bit add, wraps 511->0. len>512 is legal and revisits locations.
//  mem_adr/reg_adr hold their last value when idle. we is never 1 outside WRITE.
//  busy = (state!=IDLE). New commands are ignored while busy (cmd_ready=0).
//  Reset mid-transfer: returns to the reset state immediately.
//   A partial write leaves the memory partially updated. The FIFO is flushed.
// TESTING
//  1 Write mem=2, base=0x010, len=4, bytes A1..A4 with wr_valid held ->
//    we high 4 consecutive cycles, reg_adr 0x010..0x013, mem_adr=2, done 1 cycle later.
//  2 Read back the same region with rd_ready=1 -> rd_data A1,A2,A3,A4 in order,
//    no gaps after the first byte, done after the last pop.
//  3 Read base=0x1FE, len=4, rd_ready held low 10 cycles ->
//    at most 4 issues (reg_adr 1FE,1FF,000,001), rd_valid=1 stable, no loss when rd_ready rises.
//  4 Write base=0x1FF, len=2 -> second write goes to reg_adr 0x000.
//    Random wr_valid gaps -> we only on accepted bytes.
//  5 cmd_len=0 (write and read) -> no we, no read issue, done pulses 2 cycles after accept.
//  6 Assert rst_n=0 mid-read with a full FIFO ->
//    rd_valid=0, we=0, busy=0 same cycle, cmd_ready=1 after release.

Source files
------------

// File: rtl/npu_mem_loader.sv
// npu_mem_loader: command-driven byte mover in front of a 512x8 NPU memory.
//  Write command: streams bytes from wr_valid/wr_ready into the selected memory.
//  Read command : issues reads (1-cycle address, data one cycle later) into a
//                 small first-word-fall-through FIFO drained over rd_valid/rd_ready.
// Ports:
//  clk, rst_n                         clock, async active-low reset
//  cmd_valid/cmd_ready, cmd_write,
//  cmd_mem, cmd_base, cmd_len         command handshake and payload
//  wr_valid/wr_ready, wr_data         write-byte stream in
//  rd_valid/rd_ready, rd_data         read-byte stream out
//  mem_adr, reg_adr, din, we          memory request (registered)
//  ram_dout                           memory read data
//  busy, done                         status (done is a one-cycle pulse)
module npu_mem_loader #(
  parameter int WIDTH    = 8,
  parameter int MEMSEL_W = 6,
  parameter int REGSEL_W = 9,
  parameter int LEN_W    = 10,
  parameter int RFIFO_D  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [MEMSEL_W-1:0] cmd_mem,
  input  logic [REGSEL_W-1:0] cmd_base,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                wr_valid,
  input  logic [WIDTH-1:0]    wr_data,
  output logic                wr_ready,
  output logic                rd_valid,
  output logic [WIDTH-1:0]    rd_data,
  input  logic                rd_ready,
  output logic [MEMSEL_W-1:0] mem_adr,
  output logic [REGSEL_W-1:0] reg_adr,
  output logic [WIDTH-1:0]    din,
  output logic                we,
  input  logic [WIDTH-1:0]    ram_dout,
  output logic                busy,
  output logic                done
);

  localparam int PW = $clog2(RFIFO_D);
  localparam int CW = PW + 1;
  localparam logic [LEN_W-1:0] LEN_ONE = 1;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [MEMSEL_W-1:0] mem_q, mem_d;
  logic [REGSEL_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]    len_q, len_d, cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [WIDTH-1:0]    din_q, din_d;
  logic [REGSEL_W-1:0] reg_adr_q, reg_adr_d;
  logic [MEMSEL_W-1:0] mem_adr_q, mem_adr_d;
  logic                done_q;
  // Read pipeline: v1 = address cycle, v2 = data cycle (pushed at its end).
  logic                v1_q, v2_q;

  logic [WIDTH-1:0]    fifo_q [RFIFO_D];
  logic [PW-1:0]       wptr_q, rptr_q;
  logic [CW-1:0]       count_q;

  logic                cnt_lt_len, wr_acc, issue, push, pop, cmd_acc;
  logic [1:0]          inflight;
  logic [CW:0]         occ;

  assign cnt_lt_len = cnt_q < len_q;
  assign inflight   = {1'b0, v1_q} + {1'b0, v2_q};
  // Reserve FIFO space for every read already issued so pushes never overflow.
  assign occ        = (CW+1)'(count_q) + (CW+1)'(inflight);

  assign cmd_ready  = (state_q == S_IDLE);
  assign cmd_acc    = cmd_valid && cmd_ready;
  assign wr_ready   = (state_q == S_WRITE) && cnt_lt_len;
  assign wr_acc     = wr_ready && wr_valid;
  assign issue      = (state_q == S_READ) && cnt_lt_len && (occ < (CW+1)'(RFIFO_D));
  assign push       = v2_q;
  assign rd_valid   = (count_q != '0);
  assign rd_data    = fifo_q[rptr_q];
  assign pop        = rd_valid && rd_ready;

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign we      = we_q;
  assign din     = din_q;
  assign reg_adr = reg_adr_q;
  assign mem_adr = mem_adr_q;

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    base_d    = base_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    we_d      = 1'b0;
    din_d     = din_q;
    reg_adr_d = reg_adr_q;
    mem_adr_d = mem_adr_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          mem_d  = cmd_mem;
          base_d = cmd_base;
          len_d  = cmd_len;
          cnt_d  = '0;
          if (cmd_len == '0)  state_d = S_DONE;
          else if (cmd_write) state_d = S_WRITE;
          else                state_d = S_READ;
        end
      end
      S_WRITE: begin
        if (wr_acc) begin
          we_d      = 1'b1;
          din_d     = wr_data;
          reg_adr_d = base_q + cnt_q[REGSEL_W-1:0];
          mem_adr_d = mem_q;
          cnt_d     = cnt_q + LEN_ONE;
          if ((cnt_q + LEN_ONE) == len_q) state_d = S_DONE;
        end
      end
      S_READ: begin
        if (issue) begin
          reg_adr_d = base_q + cnt_q[REGSEL_W-1:0];
          mem_adr_d = mem_q;
          cnt_d     = cnt_q + LEN_ONE;
          if ((cnt_q + LEN_ONE) == len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (inflight == 2'd0 && count_q == '0) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mem_q     <= '0;
      base_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      din_q     <= '0;
      reg_adr_q <= '0;
      mem_adr_q <= '0;
      done_q    <= 1'b0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      base_q    <= base_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      din_q     <= din_d;
      reg_adr_q <= reg_adr_d;
      mem_adr_q <= mem_adr_d;
      done_q    <= (state_q == S_DONE);
      v1_q      <= issue;
      v2_q      <= v1_q;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; validity is carried entirely by count_q.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= ram_dout;
  end

endmodule

// File: tb/tb_npu_mem_loader.sv
module tb_npu_mem_loader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [5:0] cmd_mem = '0;
  logic [8:0] cmd_base = '0;
  logic [9:0] cmd_len = '0;
  logic       wr_valid = 1'b0, wr_ready;
  logic [7:0] wr_data = '0;
  logic       rd_valid, rd_ready = 1'b0;
  logic [7:0] rd_data;
  logic [5:0] mem_adr;
  logic [8:0] reg_adr;
  logic [7:0] din, ram_dout;
  logic       we, busy, done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  npu_mem_loader #(.WIDTH(8), .MEMSEL_W(6), .REGSEL_W(9), .LEN_W(10), .RFIFO_D(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_mem(cmd_mem), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .mem_adr(mem_adr), .reg_adr(reg_adr), .din(din), .we(we),
    .ram_dout(ram_dout), .busy(busy), .done(done)
  );

  // Synchronous-read memory: address registered on one edge, data valid after it.
  logic [7:0] ram [0:63][0:511];
  always @(posedge clk) begin
    if (we) ram[mem_adr][reg_adr] <= din;
    ram_dout <= ram[mem_adr][reg_adr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic w, input logic [5:0] m, input logic [8:0] b,
                          input logic [9:0] l);
    cmd_write = w; cmd_mem = m; cmd_base = b; cmd_len = l;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin : main
    int n;
    int k;
    logic [8:0] ra;
    logic [8:0] ea;
    logic vpat [5];
    vpat[0] = 1'b0; vpat[1] = 1'b1; vpat[2] = 1'b0; vpat[3] = 1'b0; vpat[4] = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_we", we, 0);
    chk("rst_mem_adr", mem_adr, 0);
    chk("rst_reg_adr", reg_adr, 0);
    chk("rst_din", din, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_cmd_ready", cmd_ready, 1);

    // 1: write mem2 base 0x010 len4, wr_valid held
    wr_valid = 1'b1; wr_data = 8'hA1;
    send_cmd(1'b1, 6'd2, 9'h010, 10'd4);
    chk("w1_busy", busy, 1);
    chk("w1_cmd_ready", cmd_ready, 0);
    chk("w1_wr_ready", wr_ready, 1);
    chk("w1_we_idle", we, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("w1_we", we, 1);
      chk("w1_reg_adr", reg_adr, 32'h010 + i);
      chk("w1_mem_adr", mem_adr, 2);
      chk("w1_din", din, 32'hA1 + i);
      wr_data = 8'hA2 + 8'(i);
    end
    chk("w1_wr_ready_end", wr_ready, 0);
    chk("w1_done_early", done, 0);
    wr_valid = 1'b0;
    tick();
    chk("w1_we_off", we, 0);
    chk("w1_done", done, 1);
    tick();
    chk("w1_done_pulse", done, 0);
    chk("w1_idle", busy, 0);
    chk("w1_cmd_ready", cmd_ready, 1);

    // 2: read back mem2 base 0x010 len4, rd_ready high
    rd_ready = 1'b1;
    send_cmd(1'b0, 6'd2, 9'h010, 10'd4);
    n = 0;
    while (rd_valid !== 1'b1 && n < 20) begin tick(); n++; end
    chk("r2_first_lat", n, 3);
    for (int i = 0; i < 4; i++) begin
      chk("r2_rd_valid", rd_valid, 1);
      chk("r2_rd_data", rd_data, 32'hA1 + i);
      tick();
    end
    wait_done(n);
    chk("r2_done", done, 1);
    chk("r2_done_lat", n, 2);
    rd_ready = 1'b0;
    tick();

    // 5: zero-length write and read
    ra = reg_adr;
    send_cmd(1'b1, 6'd2, 9'h055, 10'd0);
    chk("z_w_busy", busy, 1);
    chk("z_w_wr_ready", wr_ready, 0);
    chk("z_w_done_early", done, 0);
    tick();
    chk("z_w_done", done, 1);
    chk("z_w_we", we, 0);
    chk("z_w_reg_adr", reg_adr, ra);
    send_cmd(1'b0, 6'd2, 9'h066, 10'd0);
    chk("z_r_done_early", done, 0);
    tick();
    chk("z_r_done", done, 1);
    chk("z_r_rd_valid", rd_valid, 0);
    chk("z_r_reg_adr", reg_adr, ra);
    tick();

    // 4: write base 0x1FF len2 with wr_valid gaps -> wraps to 0x000
    send_cmd(1'b1, 6'd4, 9'h1FF, 10'd2);
    k = 0;
    for (int s = 0; s < 5; s++) begin
      wr_valid = vpat[s];
      wr_data = 8'hC1 + 8'(k);
      chk("w4_wr_ready", wr_ready, 1);
      tick();
      if (vpat[s]) begin
        ea = 9'h1FF + 9'(k);
        chk("w4_we_acc", we, 1);
        chk("w4_reg_adr", reg_adr, ea);
        chk("w4_din", din, 32'hC1 + k);
        k++;
      end else begin
        chk("w4_we_gap", we, 0);
      end
    end
    wr_valid = 1'b0;
    wait_done(n);
    chk("w4_done", done, 1);
    tick();

    // Load mem3 locations 0x1FE..0x003 with 30..35 for the read tests
    wr_valid = 1'b1; wr_data = 8'h30;
    send_cmd(1'b1, 6'd3, 9'h1FE, 10'd6);
    for (int i = 0; i < 6; i++) begin
      tick();
      wr_data = 8'h31 + 8'(i);
    end
    wr_valid = 1'b0;
    wait_done(n);
    chk("ld_done", done, 1);
    tick();

    // 3: read base 0x1FE len4 with rd_ready low for 10 cycles
    send_cmd(1'b0, 6'd3, 9'h1FE, 10'd4);
    for (int i = 0; i < 4; i++) begin
      tick();
      ea = 9'h1FE + 9'(i);
      chk("r3_reg_adr", reg_adr, ea);
      chk("r3_mem_adr", mem_adr, 3);
      chk("r3_we", we, 0);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("r3_hold_valid", rd_valid, 1);
      chk("r3_hold_data", rd_data, 32'h30);
      chk("r3_hold_adr", reg_adr, 32'h001);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("r3_rd_valid", rd_valid, 1);
      chk("r3_rd_data", rd_data, 32'h30 + i);
      tick();
    end
    wait_done(n);
    chk("r3_done", done, 1);
    rd_ready = 1'b0;
    tick();

    // 6: read len6 with sink stalled; credit stops issue at 4, then reset mid-read
    send_cmd(1'b0, 6'd3, 9'h1FE, 10'd6);
    for (int i = 0; i < 8; i++) tick();
    chk("r6_credit_adr", reg_adr, 32'h001);
    chk("r6_rd_valid", rd_valid, 1);
    chk("r6_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("r6_rst_rd_valid", rd_valid, 0);
    chk("r6_rst_we", we, 0);
    chk("r6_rst_busy", busy, 0);
    chk("r6_rst_done", done, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("r6_cmd_ready", cmd_ready, 1);
    chk("r6_rd_valid_after", rd_valid, 0);
    chk("r6_reg_adr_after", reg_adr, 0);
    // Fresh read must return memory data, not stale FIFO contents
    rd_ready = 1'b1;
    send_cmd(1'b0, 6'd3, 9'h1FF, 10'd1);
    n = 0;
    while (rd_valid !== 1'b1 && n < 20) begin tick(); n++; end
    chk("r6_fresh_lat", n, 3);
    chk("r6_fresh_data", rd_data, 32'h31);
    wait_done(n);
    chk("r6_fresh_done", done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
